// File: rtl/hd44780_pkg.sv
// Shared HD44780 bus constants: FSM encoding, special command codes and
// default tick counts shared with the init sequencer.
package hd44780_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_E_HI  = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_EXEC  = 3'd4;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam int DEF_SETUP_TICKS     = 1;
  localparam int DEF_E_HIGH_TICKS    = 2;
  localparam int DEF_HOLD_TICKS      = 1;
  localparam int DEF_EXEC_TICKS      = 40;
  localparam int DEF_LONG_EXEC_TICKS = 1600;

  // Clear and home need the long execution wait; only as commands, not data.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d == CMD_CLEAR || d == CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_tick_timer.sv
// Tick generator (rising edge of clkdvd) and per-state down-counter.
// done pulses on the tick that ends a state loaded with N, i.e. after N ticks.
module lcd_tick_timer #(
  parameter int TW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clkdvd,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic          clkdvd_q;
  logic          tick;
  logic [TW-1:0] timer;

  assign tick = clkdvd & ~clkdvd_q;
  assign done = tick && (timer == TW'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      clkdvd_q <= 1'b0;
      timer    <= '0;
    end else begin
      clkdvd_q <= clkdvd;
      if (load)
        timer <= load_val;
      else if (tick && timer != '0)
        timer <= timer - TW'(1);
    end
  end

endmodule

// File: rtl/lcd_bus_writer.sv
// HD44780 bus writer: byte + RS over valid/ready, emitted as two nibbles (or one
// nibble with in_nib). Define LCD_8BIT_EN for a full 8-bit bus, one E pulse per write.
module lcd_bus_writer
  import hd44780_pkg::*;
#(
  parameter int SETUP_TICKS     = DEF_SETUP_TICKS,
  parameter int E_HIGH_TICKS    = DEF_E_HIGH_TICKS,
  parameter int HOLD_TICKS      = DEF_HOLD_TICKS,
  parameter int EXEC_TICKS      = DEF_EXEC_TICKS,
  parameter int LONG_EXEC_TICKS = DEF_LONG_EXEC_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkdvd,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  input  logic       in_nib,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_d
);

  localparam int TW = $clog2(LONG_EXEC_TICKS + 1);

  state_t        state, state_nx;
  logic          done;
  logic          load;
  logic [TW-1:0] load_val;
  logic          hs;
  logic [7:0]    data_q;
  logic          rs_q;
  logic          need_second;

  assign hs = in_valid && (state == ST_IDLE);

`ifdef LCD_8BIT_EN
  assign need_second = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      rs_q   <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_d  <= '0;
    end else if (hs) begin
      data_q <= in_data;
      rs_q   <= in_rs;
      lcd_rs <= in_rs;
      lcd_d  <= in_data;
    end
  end
`else
  logic nib_q;
  logic second_q;

  assign need_second = !nib_q && !second_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q   <= '0;
      rs_q     <= 1'b0;
      nib_q    <= 1'b0;
      second_q <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_d    <= '0;
    end else if (hs) begin
      data_q   <= in_data;
      rs_q     <= in_rs;
      nib_q    <= in_nib;
      second_q <= 1'b0;
      lcd_rs   <= in_rs;
      lcd_d    <= {in_data[7:4], 4'h0};
    end else if (state == ST_HOLD && done && need_second) begin
      // Low nibble rides on the upper data lines as well.
      second_q <= 1'b1;
      lcd_d    <= {data_q[3:0], 4'h0};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nx = ST_SETUP;
      ST_SETUP: if (done)     state_nx = ST_E_HI;
      ST_E_HI:  if (done)     state_nx = ST_HOLD;
      ST_HOLD:  if (done)     state_nx = need_second ? ST_SETUP : ST_EXEC;
      ST_EXEC:  if (done)     state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // Timer reloads on every entry into a timed state.
  always_comb begin
    load     = (state_nx != state) && (state_nx != ST_IDLE);
    load_val = '0;
    case (state_nx)
      ST_SETUP: load_val = TW'(SETUP_TICKS);
      ST_E_HI:  load_val = TW'(E_HIGH_TICKS);
      ST_HOLD:  load_val = TW'(HOLD_TICKS);
      ST_EXEC:  load_val = is_long_cmd(rs_q, data_q) ? TW'(LONG_EXEC_TICKS) : TW'(EXEC_TICKS);
      default:  load_val = '0;
    endcase
  end

  always_comb begin
    lcd_e    = (state == ST_E_HI);
    in_ready = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
  end

  lcd_tick_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clkdvd   (clkdvd),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

endmodule
